// File: rtl/parity_pkg.sv
// Shared types and constants for the streaming parity accumulator family.
package parity_pkg;

   typedef enum logic [1:0] {
      P_IDLE  = 2'd0,
      P_ACCUM = 2'd1,
      P_HOLD  = 2'd2
   } par_state_e;

   localparam bit PAR_EVEN = 1'b0;
   localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_lane_reduce.sv
// Combinational per-lane XOR reduction of one beat.
// Bit k of lane_par is the XOR of lane k = s_data[k*LW +: LW].
module parity_lane_reduce #(
   parameter int DATA_W = 8,
   parameter int LANES  = 1
) (
   input  logic [DATA_W-1:0] s_data,
   output logic [LANES-1:0]  lane_par
);

   localparam int LW = DATA_W / LANES;

   // reduce each lane independently
   always_comb begin
      lane_par = '0;
      for (int k = 0; k < LANES; k++) begin
         lane_par[k] = ^s_data[k*LW +: LW];
      end
   end

endmodule

// File: rtl/parity_stream_acc.sv
// Streaming parity accumulator: folds a packet of beats into per-lane parity
// plus a saturating beat count, and presents one registered result per packet.
//
// state   | meaning
// --------+-------------------------------------------------------------
// P_IDLE  | waiting for the first beat of a packet; mode is latched here
// P_ACCUM | mid-packet; beats fold into acc/cnt until s_last
// P_HOLD  | result presented on m_*; input stalled until m_ready
module parity_stream_acc
   import parity_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int LANES  = 1,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode_odd,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [LANES-1:0]  m_parity,
   output logic [CNT_W-1:0]  m_count,
   output logic              m_sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   par_state_e       state_q, state_d;
   logic [LANES-1:0] acc_q, acc_d;
   logic [LANES-1:0] lane_par;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic             mode_q, mode_d;
   logic             accept;
   logic             load_out;

   parity_lane_reduce #(
      .DATA_W (DATA_W),
      .LANES  (LANES)
   ) u_reduce (
      .s_data   (s_data),
      .lane_par (lane_par)
   );

   // ready depends on state only so upstream never sees a valid->ready loop
   assign s_ready  = (state_q != P_HOLD);
   assign accept   = s_valid && s_ready;
   assign load_out = accept && s_last;

   // next-state and accumulator update; data is only looked at on accept
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      mode_d  = mode_q;
      case (state_q)
         P_IDLE: begin
            if (accept) begin
               mode_d  = mode_odd;
               acc_d   = lane_par;
               cnt_d   = CNT_ONE;
               sat_d   = 1'b0;
               state_d = s_last ? P_HOLD : P_ACCUM;
            end
         end
         P_ACCUM: begin
            if (accept) begin
               acc_d = acc_q ^ lane_par;
               if (cnt_q == CNT_MAX) begin
                  sat_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
               if (s_last) begin
                  state_d = P_HOLD;
               end
            end
         end
         P_HOLD: begin
            if (m_ready) begin
               state_d = P_IDLE;
            end
         end
         default: begin
            state_d = P_IDLE;
         end
      endcase
   end

   // state and accumulator registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= P_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         mode_q  <= PAR_EVEN;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
         mode_q  <= mode_d;
      end
   end

   // result registers load on the edge that accepts the last beat and then
   // hold their value, including after the result has been consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid  <= 1'b0;
         m_parity <= '0;
         m_count  <= '0;
         m_sat    <= 1'b0;
      end else begin
         m_valid <= (state_d == P_HOLD);
         if (load_out) begin
            m_parity <= acc_d ^ {LANES{mode_d}};
            m_count  <= cnt_d;
            m_sat    <= sat_d;
         end
      end
   end

endmodule
